// File: rtl/pipe_fetch_unit.sv
// pipe_fetch_unit: instruction-fetch stage between the PC register and decode.
// Issues in-order fetches to instruction memory, tracks granted-but-unreturned
// requests, buffers returned words with their PC+4, and drops stale responses
// after a redirect.
//
// Handshakes:
//   imem: a request transfers on an edge where imem_req && imem_gnt. Responses
//         (imem_rvalid) return in request order, at least one cycle after their
//         grant, and are always accepted.
//   id:   the head entry transfers on an edge where id_valid && id_ready.
//         id_valid never depends on id_ready.
module pipe_fetch_unit #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] RESET_PC4 = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] pc,
    output logic        pc_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
    input  logic        id_ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    // Instruction queue: {inst, pc4} entries handed to decode.
    logic [31:0]   q_inst_q [DEPTH];
    logic [31:0]   q_pc4_q  [DEPTH];
    logic [AW-1:0] q_rd_q, q_wr_q;
    logic [CW-1:0] q_cnt_q, q_cnt_d;

    // In-flight FIFO: pc4 of every granted request whose data is still pending.
    logic [31:0]   f_pc4_q [DEPTH];
    logic [AW-1:0] f_rd_q, f_wr_q;
    logic [CW-1:0] f_cnt_q, f_cnt_d;

    // Number of in-flight responses still to be discarded after a redirect.
    logic [CW-1:0] kill_q, kill_d;

    logic [CW:0] credit_used;
    logic        grant;
    logic        rsp;
    logic        live;
    logic        q_pop;

    // Credit: in-flight plus queued may never exceed the queue capacity, so a
    // live response always finds a free slot.
    assign credit_used = {1'b0, f_cnt_q} + {1'b0, q_cnt_q};
    assign imem_req    = !clr && !flush && (credit_used < DEPTH_W);
    assign imem_addr   = pc;
    assign grant       = imem_req && imem_gnt;
    // A redirect always loads the target; reset overrides everything.
    assign pc_en       = !clr && (grant || flush);

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp   = imem_rvalid && (f_cnt_q != '0);
    assign live  = rsp && (kill_q == '0) && !flush;
    assign q_pop = id_valid && id_ready && !flush;

    assign id_valid = (q_cnt_q != '0);
    assign id_inst  = id_valid ? q_inst_q[q_rd_q] : 32'h0000_0000;
    assign id_pc4   = id_valid ? q_pc4_q[q_rd_q]  : RESET_PC4;

    // Next-state arithmetic for the three counters.
    always_comb begin
        f_cnt_d = f_cnt_q + CW'(grant) - CW'(rsp);
        if (flush) begin
            q_cnt_d = '0;
            // Every request still in flight after this edge belongs to the old
            // path; a response consumed on this edge is already gone. Counting
            // from the outstanding total (not adding to the old kill value)
            // keeps kill bounded by DEPTH across back-to-back redirects.
            kill_d  = f_cnt_q - CW'(rsp);
        end else begin
            q_cnt_d = q_cnt_q + CW'(live) - CW'(q_pop);
            kill_d  = kill_q - CW'(rsp && (kill_q != '0));
        end
    end

    // Control state: pointers, counts and kill counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            q_rd_q  <= '0;
            q_wr_q  <= '0;
            q_cnt_q <= '0;
            f_rd_q  <= '0;
            f_wr_q  <= '0;
            f_cnt_q <= '0;
            kill_q  <= '0;
        end else begin
            q_cnt_q <= q_cnt_d;
            f_cnt_q <= f_cnt_d;
            kill_q  <= kill_d;
            if (grant) f_wr_q <= f_wr_q + 1'b1;
            if (rsp)   f_rd_q <= f_rd_q + 1'b1;
            if (flush) begin
                q_rd_q <= q_wr_q;
            end else begin
                if (live)  q_wr_q <= q_wr_q + 1'b1;
                if (q_pop) q_rd_q <= q_rd_q + 1'b1;
            end
        end
    end

    // Data storage: written only under the same conditions that advance the
    // write pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!clr && grant) f_pc4_q[f_wr_q] <= pc + 32'd4;
        if (!clr && live) begin
            q_inst_q[q_wr_q] <= imem_rdata;
            q_pc4_q[q_wr_q]  <= f_pc4_q[f_rd_q];
        end
    end

endmodule

// File: tb/tb_pipe_fetch_unit.sv
`timescale 1ns/1ps
module tb_pipe_fetch_unit;

    localparam int          DEPTH     = 2;
    localparam logic [31:0] RESET_PC4 = 32'h0000_0004;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] pc;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;
    logic        id_ready;

    always #5 clk = ~clk;

    pipe_fetch_unit #(.DEPTH(DEPTH), .RESET_PC4(RESET_PC4)) dut (
        .clk(clk), .clr(clr), .pc(pc), .pc_en(pc_en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .flush(flush),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc4(id_pc4), .id_ready(id_ready)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: decode-visible instructions, in-flight requests with a
    // stale flag, and the memory's pending responses.
    logic [63:0] exp_q[$];   // {inst, pc4}
    logic [32:0] infl_q[$];  // {stale, pc4}
    logic [63:0] mem_q[$];   // {due_cycle, data}
    logic [31:0] got_q[$];   // pc4 of every instruction decode consumed

    // stimulus knobs
    int          gnt_pct, rsp_pct, rdy_pct, lat_min, lat_max;
    logic        clr_req, flush_req;
    logic [31:0] flush_tgt, pc_next, data_next;

    // observations from the last step
    logic        obs_req, obs_pc_en, obs_valid;
    logic [31:0] obs_inst, obs_pc4;

    // One clock: drive at negedge, compare 1ns later, update the model after posedge.
    task automatic step();
        logic        e_req, e_grant, e_pc_en, rsp, pop;
        logic [32:0] f;
        logic [31:0] e_inst, e_pc4;
        f = '0;
        @(negedge clk);
        pc          = pc_next;
        clr         = clr_req;
        flush       = flush_req;
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        id_ready    = ($urandom_range(99) < rdy_pct);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (!clr_req && mem_q.size() > 0 && int'(mem_q[0][63:32]) <= cyc &&
            $urandom_range(99) < rsp_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0][31:0];
        end
        #1;
        e_req   = !clr && !flush && ((infl_q.size() + exp_q.size()) < DEPTH);
        e_grant = e_req && imem_gnt;
        e_pc_en = !clr && (e_grant || flush);
        e_inst  = (exp_q.size() != 0) ? exp_q[0][63:32] : 32'h0;
        e_pc4   = (exp_q.size() != 0) ? exp_q[0][31:0]  : RESET_PC4;
        chk("imem_req",  32'(imem_req),  32'(e_req));
        chk("pc_en",     32'(pc_en),     32'(e_pc_en));
        chk("imem_addr", imem_addr,      pc);
        chk("id_valid",  32'(id_valid),  32'(exp_q.size() != 0));
        chk("id_inst",   id_inst,        e_inst);
        chk("id_pc4",    id_pc4,         e_pc4);
        obs_req   = imem_req;
        obs_pc_en = pc_en;
        obs_valid = id_valid;
        obs_inst  = id_inst;
        obs_pc4   = id_pc4;
        pop = (exp_q.size() != 0) && id_ready && !flush && !clr;
        if (pop) got_q.push_back(id_pc4);
        @(posedge clk);
        if (clr) begin
            exp_q.delete();
            infl_q.delete();
            mem_q.delete();
        end else begin
            rsp = imem_rvalid && (infl_q.size() > 0);
            if (imem_rvalid) void'(mem_q.pop_front());
            if (rsp) f = infl_q.pop_front();
            if (flush) begin
                exp_q.delete();
                foreach (infl_q[i]) infl_q[i][32] = 1'b1;
            end else begin
                if (pop) void'(exp_q.pop_front());
                if (rsp && !f[32]) exp_q.push_back({imem_rdata, f[31:0]});
            end
            if (e_grant) begin
                infl_q.push_back({1'b0, pc + 32'd4});
                mem_q.push_back({32'(cyc + $urandom_range(lat_max, lat_min)), data_next});
                data_next = data_next + 32'd1;
            end
        end
        if (e_pc_en) pc_next = flush ? flush_tgt : pc + 32'd4;
        cyc++;
    endtask

    task automatic reset_dut(input logic [31:0] start_pc);
        clr_req   = 1'b1;
        flush_req = 1'b0;
        pc_next   = start_pc;
        step();
        step();
        clr_req   = 1'b0;
    endtask

    task automatic set_knobs(input int g, input int r, input int d, input int lmin, input int lmax);
        gnt_pct = g; rsp_pct = r; rdy_pct = d; lat_min = lmin; lat_max = lmax;
    endtask

    // Step until decode sees a valid head (bounded), then leave obs_* on it.
    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        step();
        while (!obs_valid && n < budget) begin
            step();
            n++;
        end
        chk({name, "_seen"}, 32'(obs_valid), 32'd1);
    endtask

    // ---------------- table-driven request/credit vectors ----------------
    typedef struct {
        logic        clr;
        logic        flush;
        logic        gnt;
        logic [31:0] pc;
        logic        e_req;
        logic        e_pc_en;
    } vec_t;

    vec_t vecs[7];

    logic [31:0] stream_exp[6];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h0000_0104, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_0108, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_010C, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h0000_0110, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1};
        for (int k = 0; k < 6; k++) stream_exp[k] = 32'h0000_0104 + 32'(4 * k);

        clr = 1'b1; flush = 1'b0; pc = 32'h0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
        clr_req = 1'b1; flush_req = 1'b0; flush_tgt = 32'h0;
        pc_next = 32'h0; data_next = 32'h1000_0000;
        set_knobs(100, 100, 100, 1, 1);
        repeat (2) @(posedge clk);

        // Each vector starts from the reset state and is followed by a reset edge.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            clr = vecs[i].clr; flush = vecs[i].flush; imem_gnt = vecs[i].gnt;
            pc = vecs[i].pc; imem_rvalid = 1'b0; id_ready = 1'b0;
            #1;
            chk("vec_req",   32'(imem_req), 32'(vecs[i].e_req));
            chk("vec_pc_en", 32'(pc_en),    32'(vecs[i].e_pc_en));
            chk("vec_addr",  imem_addr,     vecs[i].pc);
            chk("vec_valid", 32'(id_valid), 32'd0);
            chk("vec_inst",  id_inst,       32'h0);
            chk("vec_pc4",   id_pc4,        RESET_PC4);
            @(negedge clk);
            clr = 1'b1; flush = 1'b0; imem_gnt = 1'b0;
            @(posedge clk);
        end

        // Steady stream from 0x100, then a decode stall and drain.
        set_knobs(100, 100, 100, 1, 1);
        reset_dut(32'h0000_0100);
        got_q.delete();
        repeat (20) step();
        chk("stream_count", 32'(got_q.size() >= 6), 32'd1);
        for (int k = 0; k < 6; k++)
            if (k < got_q.size()) chk("stream_pc4", got_q[k], stream_exp[k]);
        rdy_pct = 0;
        repeat (5) step();
        chk("stall_valid", 32'(obs_valid), 32'd1);
        chk("stall_req",   32'(obs_req),   32'd0);
        chk("stall_pc_en", 32'(obs_pc_en), 32'd0);
        rdy_pct = 100;
        repeat (10) step();

        // Redirect with two requests outstanding and no responses yet.
        set_knobs(100, 0, 100, 1, 1);
        reset_dut(32'h0000_0200);
        data_next = 32'hDEAD_0001;
        step();
        step();
        data_next = 32'h1111_0000;
        flush_tgt = 32'h0000_0400;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        rsp_pct   = 100;
        wait_valid("flush2", 20);
        chk("flush2_pc4",  obs_pc4,  32'h0000_0404);
        chk("flush2_inst", obs_inst, 32'h1111_0000);

        // Redirect on the same edge as the first of two responses.
        set_knobs(100, 0, 100, 1, 1);
        reset_dut(32'h0000_0300);
        data_next = 32'hBAD0_0001;
        step();
        step();
        rsp_pct   = 100;
        data_next = 32'h2222_0000;
        flush_tgt = 32'h0000_0500;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        step();
        chk("flushc_empty", 32'(obs_valid), 32'd0);
        wait_valid("flushc", 20);
        chk("flushc_pc4",  obs_pc4,  32'h0000_0504);
        chk("flushc_inst", obs_inst, 32'h2222_0000);

        // Memory backpressure: request held, PC not advanced.
        set_knobs(0, 100, 100, 1, 1);
        reset_dut(32'h0000_0600);
        repeat (3) begin
            step();
            chk("bp_req",   32'(obs_req),   32'd1);
            chk("bp_pc_en", 32'(obs_pc_en), 32'd0);
        end

        // PC+4 wraps to zero.
        set_knobs(100, 100, 100, 1, 1);
        reset_dut(32'hFFFF_FFFC);
        wait_valid("wrap", 20);
        chk("wrap_pc4", obs_pc4, 32'h0000_0000);

        // Reset with a full queue.
        set_knobs(100, 100, 0, 1, 1);
        reset_dut(32'h0000_0700);
        repeat (6) step();
        chk("prerst_valid", 32'(obs_valid), 32'd1);
        clr_req = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(obs_valid), 32'd0);
        chk("rst_req",   32'(obs_req),   32'd0);
        chk("rst_pc4",   obs_pc4,        RESET_PC4);
        clr_req = 1'b0;
        step();
        chk("rst_req_after", 32'(obs_req), 32'd1);

        // Randomized traffic with redirects and occasional resets.
        set_knobs(70, 70, 60, 1, 3);
        for (int n = 0; n < 3000; n++) begin
            flush_req = ($urandom_range(99) < 4);
            flush_tgt = $urandom & 32'hFFFF_FFFC;
            clr_req   = ($urandom_range(999) < 5);
            if (n % 500 == 0) begin
                gnt_pct = $urandom_range(100, 30);
                rsp_pct = $urandom_range(100, 30);
                rdy_pct = $urandom_range(100, 20);
            end
            step();
        end
        clr_req = 1'b0;
        flush_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
